decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Fetch buffer (2**BUF_WIDTH entries) feeding an RV32I field decoder with a registered output stage.
// Define DECODER_STATIC_PRED_EN to enable static backward-branch / JAL prediction with fetch redirect.
module decoder #(
    parameter int unsigned BUF_WIDTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_valid,
    input  logic [31:0] if_ins,
    input  logic [31:0] if_pc,
    output logic        dec_full,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic        out_illegal,
    output logic        out_pred_taken,
    output logic        pred_redirect,
    output logic [31:0] pred_target
);

    localparam int unsigned DEPTH = 1 << BUF_WIDTH;
    localparam logic [BUF_WIDTH+1:0] OCC_MAX  = (BUF_WIDTH+2)'(DEPTH);
    localparam logic [BUF_WIDTH+1:0] OCC_FULL = (BUF_WIDTH+2)'(DEPTH - 1);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
        logic        pred_taken;
    } out_t;

    logic [63:0]          mem_q [DEPTH];
    logic [BUF_WIDTH-1:0] head_q, head_d;
    logic [BUF_WIDTH-1:0] tail_q, tail_d;
    logic [BUF_WIDTH:0]   cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 redirect_q, redirect_d;
    logic [31:0]          target_q, target_d;
    out_t                 out_q, out_d;

    out_t                 dec;
    fmt_e                 fmt;
    logic [31:0]          hd_ins, hd_pc;
    logic [BUF_WIDTH+1:0] occ;
    logic                 deq, enq, flush, wr_en;

    assign {hd_ins, hd_pc} = mem_q[head_q];

    // Occupancy includes the output register so total storage is DEPTH instructions.
    assign occ      = (BUF_WIDTH+2)'(cnt_q) + (BUF_WIDTH+2)'(out_valid_q);
    assign dec_full = (occ >= OCC_FULL);

    always_comb begin
        case (hd_ins[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:  fmt = FMT_I;
            OPC_STORE:                 fmt = FMT_S;
            OPC_BRANCH:                fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:        fmt = FMT_U;
            OPC_JAL:                   fmt = FMT_J;
            OPC_OP:                    fmt = FMT_R;
            default:                   fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = hd_ins[6:0];
        dec.funct3  = hd_ins[14:12];
        dec.funct7b = hd_ins[30];
        dec.rd      = hd_ins[11:7];
        dec.rs1     = hd_ins[19:15];
        dec.rs2     = hd_ins[24:20];
        dec.pc      = hd_pc;
        case (fmt)
            FMT_R: begin
                dec.imm = '0;
            end
            FMT_I: begin
                dec.rs2 = '0;
                dec.imm = {{20{hd_ins[31]}}, hd_ins[31:20]};
            end
            FMT_S: begin
                dec.rd  = '0;
                dec.imm = {{20{hd_ins[31]}}, hd_ins[31:25], hd_ins[11:7]};
            end
            FMT_B: begin
                dec.rd  = '0;
                dec.imm = {{19{hd_ins[31]}}, hd_ins[31], hd_ins[7],
                           hd_ins[30:25], hd_ins[11:8], 1'b0};
            end
            FMT_U: begin
                dec.rs1 = '0;
                dec.rs2 = '0;
                dec.imm = {hd_ins[31:12], 12'b0};
            end
            FMT_J: begin
                dec.rs1 = '0;
                dec.rs2 = '0;
                dec.imm = {{11{hd_ins[31]}}, hd_ins[31], hd_ins[19:12],
                           hd_ins[20], hd_ins[30:21], 1'b0};
            end
            default: begin
                dec.illegal = 1'b1;
                dec.imm     = '0;
            end
        endcase
`ifdef DECODER_STATIC_PRED_EN
        dec.pred_taken = (fmt == FMT_J) || ((fmt == FMT_B) && dec.imm[31]);
`else
        dec.pred_taken = 1'b0;
`endif
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        redirect_d  = redirect_q;
        target_d    = target_q;
        deq         = 1'b0;
        enq         = 1'b0;
        flush       = 1'b0;
        wr_en       = 1'b0;
        if (rdy_in) begin
            redirect_d = 1'b0;
            if (clear) begin
                head_d      = '0;
                tail_d      = '0;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end else begin
                deq   = (cnt_q != '0) && (!out_valid_q || out_ready);
                flush = deq && dec.pred_taken;
                // Fetches during the redirect pulse or the flushing edge are on the wrong path.
                enq   = if_valid && (occ < OCC_MAX) && !redirect_q && !flush;
                wr_en = enq;
                if (deq) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                    redirect_d  = dec.pred_taken;
                    if (dec.pred_taken) begin
                        target_d = hd_pc + dec.imm;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (flush) begin
                    head_d = '0;
                    tail_d = '0;
                    cnt_d  = '0;
                end else begin
                    if (enq) begin
                        tail_d = tail_q + BUF_WIDTH'(1);
                    end
                    if (deq) begin
                        head_d = head_q + BUF_WIDTH'(1);
                    end
                    cnt_d = cnt_q + (BUF_WIDTH+1)'(enq) - (BUF_WIDTH+1)'(deq);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            redirect_q  <= 1'b0;
            target_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            redirect_q  <= redirect_d;
            target_q    <= target_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[tail_q] <= {if_ins, if_pc};
        end
    end

    assign out_valid      = out_valid_q;
    assign out_opcode     = out_q.opcode;
    assign out_funct3     = out_q.funct3;
    assign out_funct7b    = out_q.funct7b;
    assign out_rd         = out_q.rd;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_imm        = out_q.imm;
    assign out_pc         = out_q.pc;
    assign out_illegal    = out_q.illegal;
    assign out_pred_taken = out_q.pred_taken;
    assign pred_redirect  = redirect_q;
    assign pred_target    = target_q;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: vector table through a scoreboard plus hand sequences for stall, full,
// clear, freeze, async reset and static prediction (DECODER_STATIC_PRED_EN aware).
module tb_decoder;

    localparam int unsigned BW = 2;
`ifdef DECODER_STATIC_PRED_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7b;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
        logic        tk;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        exp_t        exp;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, clear, if_valid, out_ready;
    logic [31:0] if_ins, if_pc;
    logic        dec_full, out_valid, out_funct7b, out_illegal, out_pred_taken, pred_redirect;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm, out_pc, pred_target;

    int unsigned total  = 0;
    int unsigned passed = 0;
    exp_t        sb[$];
    vec_t        vt[11];
    int          sent;

    always #5 clk_in = ~clk_in;

    decoder #(.BUF_WIDTH(BW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
        .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc), .dec_full(dec_full),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7b(out_funct7b), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
        .out_illegal(out_illegal), .out_pred_taken(out_pred_taken),
        .pred_redirect(pred_redirect), .pred_target(pred_target)
    );

    function automatic exp_t dut_out();
        return {out_opcode, out_funct3, out_funct7b, out_rd, out_rs1, out_rs2,
                out_imm, out_pc, out_illegal, out_pred_taken};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [6:0] opc, input logic [2:0] f3, input logic f7b,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic ill, input logic tk);
        vec_t v;
        v.ins = ins;
        v.pc  = pc;
        v.exp = {opc, f3, f7b, rd, rs1, rs2, imm, pc, ill, tk};
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fetch(input vec_t v, input bit push);
        if_valid = 1'b1;
        if_ins   = v.ins;
        if_pc    = v.pc;
        if (push) sb.push_back(v.exp);
        step();
        if_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) step();
        check({name, "_empty"}, sb.size(), 0);
        check({name, "_idle"}, out_valid, 0);
    endtask

    // Scoreboard: an output is consumed at the next rising edge when valid and ready.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in && rdy_in && !clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", dut_out());
            end else begin
                e = sb.pop_front();
                check("scoreboard_out", dut_out(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; if_valid = 1'b0;
        if_ins = '0; if_pc = '0; out_ready = 1'b0;

        //           ins            pc        opc    f3    f7b   rd     rs1    rs2    imm            ill   tk
        vt[0]  = mk(32'h00500093, 32'h00, 7'h13, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000005, 1'b0, 1'b0);
        vt[1]  = mk(32'h402081B3, 32'h04, 7'h33, 3'd0, 1'b1, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0, 1'b0);
        vt[2]  = mk(32'hFF812283, 32'h08, 7'h03, 3'd2, 1'b1, 5'd5,  5'd2,  5'd0,  32'hFFFFFFF8, 1'b0, 1'b0);
        vt[3]  = mk(32'h0063A623, 32'h0C, 7'h23, 3'd2, 1'b0, 5'd0,  5'd7,  5'd6,  32'h0000000C, 1'b0, 1'b0);
        vt[4]  = mk(32'h12345537, 32'h10, 7'h37, 3'd5, 1'b0, 5'd10, 5'd0,  5'd0,  32'h12345000, 1'b0, 1'b0);
        vt[5]  = mk(32'hFFFFF097, 32'h14, 7'h17, 3'd7, 1'b1, 5'd1,  5'd0,  5'd0,  32'hFFFFF000, 1'b0, 1'b0);
        vt[6]  = mk(32'h00008067, 32'h18, 7'h67, 3'd0, 1'b0, 5'd0,  5'd1,  5'd0,  32'h00000000, 1'b0, 1'b0);
        vt[7]  = mk(32'h00209863, 32'h1C, 7'h63, 3'd1, 1'b0, 5'd0,  5'd1,  5'd2,  32'h00000010, 1'b0, 1'b0);
        vt[8]  = mk(32'hFFFFFFFF, 32'h20, 7'h7F, 3'd7, 1'b1, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b1, 1'b0);
        vt[9]  = mk(32'h008000EF, 32'h24, 7'h6F, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000008, 1'b0, PRED_EN);
        vt[10] = mk(32'hFE000EE3, 32'h100, 7'h63, 3'd0, 1'b1, 5'd0, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0, PRED_EN);

        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_dec_full", dec_full, 0);
        check("rst_redirect", pred_redirect, 0);
        check("rst_target", pred_target, 0);
        check("rst_fields", dut_out(), 0);
        rst_n_in = 1'b1;
        step();

        // First instruction latency and fields
        out_ready = 1'b0;
        fetch(vt[0], 1'b1);
        check("lat_edge_n", out_valid, 0);
        step();
        check("lat_edge_n1", out_valid, 1);
        check("first_fields", dut_out(), vt[0].exp);
        drain("first");

        // Table, one instruction at a time
        for (int i = 0; i < 11; i++) begin
            fetch(vt[i], 1'b1);
            drain($sformatf("vec%0d", i));
        end

        // Back-to-back stream honouring dec_full, with stalling dispatch (pointers wrap)
        sent = 0;
        for (int c = 0; c < 80 && (sent < 9 || sb.size() != 0); c++) begin
            out_ready = ((c % 3) != 1);
            if (sent < 9 && !dec_full) begin
                if_valid = 1'b1;
                if_ins   = vt[sent].ins;
                if_pc    = vt[sent].pc;
                sb.push_back(vt[sent].exp);
                sent++;
            end else begin
                if_valid = 1'b0;
            end
            step();
        end
        if_valid = 1'b0;
        drain("stream");

        // Fill with dispatch stalled: dec_full after the 3rd, 5th fetch dropped
        out_ready = 1'b0;
        fetch(vt[0], 1'b1);
        check("full_after_1", dec_full, 0);
        fetch(vt[1], 1'b1);
        check("full_after_2", dec_full, 0);
        fetch(vt[2], 1'b1);
        check("full_after_3", dec_full, 1);
        fetch(vt[3], 1'b1);
        check("full_after_4", dec_full, 1);
        fetch(vt[4], 1'b0);
        check("stall_hold_a", dut_out(), vt[0].exp);
        step();
        check("stall_hold_b", dut_out(), vt[0].exp);
        check("stall_valid", out_valid, 1);
        drain("fill");

        // Clear with two buffered, output valid and a concurrent fetch
        out_ready = 1'b0;
        fetch(vt[0], 1'b0);
        fetch(vt[1], 1'b0);
        fetch(vt[2], 1'b0);
        check("pre_clear_valid", out_valid, 1);
        check("pre_clear_full", dec_full, 1);
        clear = 1'b1; if_valid = 1'b1; if_ins = vt[3].ins; if_pc = vt[3].pc;
        step();
        clear = 1'b0; if_valid = 1'b0;
        check("clear_valid", out_valid, 0);
        check("clear_full", dec_full, 0);
        out_ready = 1'b1;
        repeat (3) step();
        check("clear_no_stale", out_valid, 0);
        fetch(vt[5], 1'b1);
        drain("post_clear");

        // Backward branch with younger fetches behind it
        out_ready = 1'b1;
        fetch(vt[10], 1'b1);
        fetch(vt[0], !PRED_EN);
        check("bt_redirect", pred_redirect, PRED_EN);
        check("bt_target", pred_target, PRED_EN ? 32'h000000FC : 32'h0);
        check("bt_pred_taken", out_pred_taken, PRED_EN);
        fetch(vt[1], !PRED_EN);
        check("bt_pulse_end", pred_redirect, 0);
        drain("branch");

        // rdy_in low freezes everything, ignoring clear and fetch
        out_ready = 1'b0;
        fetch(vt[1], 1'b1);
        step();
        rdy_in = 1'b0; clear = 1'b1; if_valid = 1'b1; if_ins = vt[2].ins; if_pc = vt[2].pc;
        out_ready = 1'b1;
        step();
        step();
        check("freeze_valid", out_valid, 1);
        check("freeze_fields", dut_out(), vt[1].exp);
        rdy_in = 1'b1; clear = 1'b0; if_valid = 1'b0;
        drain("freeze");

        // Asynchronous reset mid-cycle with three buffered entries
        out_ready = 1'b0;
        fetch(vt[0], 1'b0);
        fetch(vt[1], 1'b0);
        fetch(vt[2], 1'b0);
        fetch(vt[3], 1'b0);
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_full", dec_full, 0);
        check("async_rst_fields", dut_out(), 0);
        #3;
        rst_n_in = 1'b1;
        step();
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_no_stale", out_valid, 0);
        out_ready = 1'b0;
        fetch(vt[8], 1'b1);
        check("ill_lat_n", out_valid, 0);
        step();
        check("ill_lat_n1", out_valid, 1);
        check("ill_flag", out_illegal, 1);
        drain("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
